index_not_sched: RTL
====================

# index_not_sched

Round-robin scheduler that shares one single-bit inverter between two requesters and runs it bit-serially across a WIDTH-bit word. It grants one requester at a time and captures the word. It then applies the inversion to one bit index per cycle, LSB first, and returns the inverted word on a response channel with backpressure. It sits in front of the inverter datapath as its sequencer and arbiter, trading throughput for a single inverter instance.

## Interface
- WIDTH, 8, word width; legal range WIDTH >= 2; the bit counter is $clog2(WIDTH) bits wide.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word; sampled only in the accept cycle.
- req0_ready  out  1  requester 0 is granted and the block is idle.
- req1_valid, req1_data, req1_ready  same as requester 0, for requester 1.
- resp_valid  out  1  resp_data/resp_id hold a completed result.
- resp_data  out  WIDTH  bitwise inverse of the accepted word.
- resp_id  out  1  requester that owns the result (0 or 1).
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in SHIFT and DONE.

## Operation
- Three-state FSM:
  - IDLE: waiting for a request.
  - SHIFT: WIDTH cycles, one bit per cycle.
  - DONE: response held until accepted.
- Arbitration, evaluated combinationally in IDLE only:
  - If only one valid is high, that requester is granted.
  - If both are high, the requester that is not last_grant is granted.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high at a time. Both readies are low outside IDLE.
- Accept: reqN_valid && reqN_ready at a clock edge.
  - Capture reqN_data into the operand register.
  - Store N into resp_id.
  - Clear cnt to 0 and go to SHIFT.
- SHIFT, each cycle:
  - result[cnt] <= ~operand[cnt] through the single inverter.
  - If cnt==WIDTH-1, go to DONE; otherwise cnt <= cnt+1.
- DONE:
  - resp_valid=1; resp_data and resp_id are stable.
  - On resp_valid && resp_ready: last_grant <= resp_id, go to IDLE.
- resp_data is the result register. Result bits not yet written in SHIFT are undefined-but-stable and are never visible while resp_valid=1.
- Requester data may change freely after the accept cycle.

## Timing
- Reset values:
  - state=IDLE, cnt=0, result=0, operand=0.
  - resp_valid=0, resp_data=0, resp_id=0, busy=0.
  - last_grant=1, so req0 wins the first contention.
- Reset mid-operation (in SHIFT or DONE): the in-flight word is discarded with no response. The block enters IDLE the cycle after the reset edge, with all outputs at reset values.
- Latency, with the accept in cycle 0:
  - SHIFT occupies cycles 1..WIDTH.
  - resp_valid rises in cycle WIDTH+1.
- If resp_ready is high in cycle WIDTH+1, the block is in IDLE in cycle WIDTH+2 and can accept again in that cycle. The minimum initiation interval is WIDTH+2 cycles.
- Backpressure: resp_valid, resp_data and resp_id hold unchanged for any number of cycles until resp_ready.
- A valid that drops before its ready is legal; that requester is simply not accepted.
- With both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- If resp_ready is held high permanently, the response is still valid for exactly one cycle.

## Test plan
- Single request, WIDTH=8: req0_data=8'hA5 accepted in cycle 0 -> resp_valid=1 in cycle 9 with resp_data=8'h5A, resp_id=0; busy high in cycles 1..9.
- Contention after reset: req0=8'h0F and req1=8'hF0, both valid in cycle 0 -> req0 accepted first (resp 8'hF0, id 0); req1 accepted in cycle 10 (resp 8'h0F, id 1, resp_valid in cycle 19).
- Fairness: both requesters valid continuously for 4 transactions with resp_ready=1 -> resp_id sequence 0,1,0,1; accepts in cycles 0,10,20,30.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_data/resp_id stable and both readies low throughout; IDLE the cycle after resp_ready=1.
- Reset mid-SHIFT: accept 8'h3C, assert rst_n=0 in cycle 4 -> cycle 5 shows IDLE, resp_valid=0, resp_data=0; no response for 8'h3C is ever emitted; next req1 accept returns the correct inverse.
- Edge patterns: 8'h00 -> 8'hFF and 8'hFF -> 8'h00; req1 alone after reset is granted immediately (req1_ready=1 in cycle 0).

Source files
------------

// File: rtl/index_not_sched.sv
// Round-robin sequencer for a single shared one-bit inverter.
// Grants one of two requesters, inverts the captured word LSB first, and returns it with backpressure.
module index_not_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    input  logic             resp_ready,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] result_q;
    logic             resp_id_q;
    logic             last_grant_q;
    logic             grant;
    logic             accept;
    logic             inv_bit;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == StIdle) && !grant;
    assign req1_ready = (state_q == StIdle) && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // The one shared inverter, steered by the bit counter.
    assign inv_bit = ~operand_q[cnt_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            operand_q    <= '0;
            result_q     <= '0;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        operand_q <= grant ? req1_data : req0_data;
                        resp_id_q <= grant;
                        cnt_q     <= '0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    result_q[cnt_q] <= inv_bit;
                    if (cnt_q == CntLast) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        last_grant_q <= resp_id_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid = (state_q == StDone);
    assign resp_data  = result_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != StIdle);

endmodule
